// File: rtl/key_code_entry_if.sv
// Handshake bundle between the key-code entry front-end and the lock FSM.
//   pin_entry   : assembled code word, first digit in the most significant nibble
//   entry_valid : code word complete and held stable until accepted
//   entry_ready : downstream accepts the code when high together with entry_valid
//   digit_count : number of digits captured in the current entry
// master = producer (key_code_entry), slave = consumer (lock FSM / testbench).
interface key_code_entry_if #(
  parameter int unsigned DIGITS = 4
);
  localparam int unsigned CODE_LENGTH = 4 * DIGITS;
  localparam int unsigned COUNT_W     = $clog2(DIGITS + 1);

  logic [CODE_LENGTH-1:0] pin_entry;
  logic                   entry_valid;
  logic                   entry_ready;
  logic [COUNT_W-1:0]     digit_count;

  modport master (
    output pin_entry,
    output entry_valid,
    output digit_count,
    input  entry_ready
  );

  modport slave (
    input  pin_entry,
    input  entry_valid,
    input  digit_count,
    output entry_ready
  );
endinterface

// File: rtl/key_code_entry.sv
// Key-code entry front-end for the digital lock.
// Synchronises and debounces four active-low push-buttons, converts each clean
// single-key press into a digit (index of the pressed key) and shifts DIGITS digits
// into a code word offered on a valid/ready handshake. A partial entry is dropped
// after TIMEOUT_CYCLES idle cycles.
// Ports:
//   clock     : system clock, rising edge
//   reset     : asynchronous, active-low
//   key       : raw push-buttons, active-low, asynchronous to clock
//   key_clean : debounced key vector, active-high
//   entry     : handshake bundle (pin_entry, entry_valid, digit_count out; entry_ready in)
module key_code_entry #(
  parameter int unsigned DIGITS          = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned TIMEOUT_CYCLES  = 250000000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [3:0]       key,
  output logic [3:0]       key_clean,
  key_code_entry_if.master entry
);

  localparam int unsigned CODE_LENGTH = 4 * DIGITS;
  localparam int unsigned CountW      = $clog2(DIGITS + 1);
  localparam int unsigned DbW         = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned ToW         = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {
    StCollect = 2'd0,
    StRelease = 2'd1,
    StPresent = 2'd2
  } state_e;

  // Input synchroniser, reset to "released" (all ones, active-low).
  logic [3:0] sync1_q, sync2_q;
  logic [3:0] synced;
  logic [3:0] synced_prev_q;

  // Debounce
  logic [DbW-1:0] db_cnt_q, db_cnt_d;
  logic [3:0]     key_clean_q, key_clean_d;
  logic           db_update;

  // Press decode
  logic       press_valid;
  logic [3:0] digit;

  // Entry FSM and datapath
  state_e                 state_q, state_d;
  logic [CODE_LENGTH-1:0] pin_q, pin_d;
  logic [CountW-1:0]      count_q, count_d;
  logic                   valid_q, valid_d;
  logic [ToW-1:0]         to_cnt_q, to_cnt_d;

  assign synced = ~sync2_q;

  // Counter restarts on any change of the synced vector and idles while it already
  // matches the accepted vector; acceptance after DEBOUNCE_CYCLES stable cycles.
  always_comb begin
    db_cnt_d    = db_cnt_q;
    key_clean_d = key_clean_q;
    db_update   = 1'b0;
    if ((synced != synced_prev_q) || (synced == key_clean_q)) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DbW'(DEBOUNCE_CYCLES - 1)) begin
      key_clean_d = synced;
      db_cnt_d    = '0;
      db_update   = 1'b1;
    end else begin
      db_cnt_d = db_cnt_q + DbW'(1);
    end
  end

  // A press is the accepted vector moving from all-released to exactly one key.
  always_comb begin
    digit = '0;
    for (int i = 0; i < 4; i++) begin
      if (synced[i]) digit = 4'(i);
    end
    press_valid = db_update && (key_clean_q == 4'b0000) && $onehot(synced);
  end

  always_comb begin
    state_d  = state_q;
    pin_d    = pin_q;
    count_d  = count_q;
    valid_d  = valid_q;
    to_cnt_d = to_cnt_q;
    case (state_q)
      StCollect, StRelease: begin
        // A press needs key_clean == 0, so accepting it in RELEASE as well only
        // covers the cycle where the release was seen but the state not yet left.
        if (press_valid) begin
          pin_d    = {pin_q[CODE_LENGTH-5:0], digit};
          count_d  = count_q + CountW'(1);
          to_cnt_d = '0;
          if (count_q == CountW'(DIGITS - 1)) begin
            state_d = StPresent;
            valid_d = 1'b1;
          end else begin
            state_d = StRelease;
          end
        end else begin
          if ((state_q == StRelease) && (key_clean_q == 4'b0000)) state_d = StCollect;
          if (count_q == '0) begin
            to_cnt_d = '0;
          end else if (to_cnt_q == ToW'(TIMEOUT_CYCLES - 1)) begin
            pin_d    = '0;
            count_d  = '0;
            to_cnt_d = '0;
          end else begin
            to_cnt_d = to_cnt_q + ToW'(1);
          end
        end
      end
      StPresent: begin
        // Keys ignored and timeout frozen; only the handshake leaves this state.
        // Leaving through RELEASE stops a still-held last key from re-entering.
        if (valid_q && entry.entry_ready) begin
          valid_d  = 1'b0;
          pin_d    = '0;
          count_d  = '0;
          to_cnt_d = '0;
          state_d  = StRelease;
        end
      end
      default: begin
        state_d  = StCollect;
        pin_d    = '0;
        count_d  = '0;
        valid_d  = 1'b0;
        to_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q       <= 4'b1111;
      sync2_q       <= 4'b1111;
      synced_prev_q <= 4'b0000;
      db_cnt_q      <= '0;
      key_clean_q   <= 4'b0000;
      state_q       <= StCollect;
      pin_q         <= '0;
      count_q       <= '0;
      valid_q       <= 1'b0;
      to_cnt_q      <= '0;
    end else begin
      sync1_q       <= key;
      sync2_q       <= sync1_q;
      synced_prev_q <= synced;
      db_cnt_q      <= db_cnt_d;
      key_clean_q   <= key_clean_d;
      state_q       <= state_d;
      pin_q         <= pin_d;
      count_q       <= count_d;
      valid_q       <= valid_d;
      to_cnt_q      <= to_cnt_d;
    end
  end

  assign key_clean         = key_clean_q;
  assign entry.pin_entry   = pin_q;
  assign entry.entry_valid = valid_q;
  assign entry.digit_count = count_q;

endmodule
